// File: rtl/armleocpu_mmu_xlate_pkg.sv
// Shared constants and types for the SV32 translation front-end and its TLB.
// Metadata bit positions follow the PTE low byte layout.
package armleocpu_mmu_xlate_pkg;

  localparam int ARMLEOCPU_PAGE_METADATA_VALID_BIT_NUM   = 0;
  localparam int ARMLEOCPU_PAGE_METADATA_READ_BIT_NUM    = 1;
  localparam int ARMLEOCPU_PAGE_METADATA_WRITE_BIT_NUM   = 2;
  localparam int ARMLEOCPU_PAGE_METADATA_EXECUTE_BIT_NUM = 3;
  localparam int ARMLEOCPU_PAGE_METADATA_USER_BIT_NUM    = 4;
  localparam int ARMLEOCPU_PAGE_METADATA_GLOBAL_BIT_NUM  = 5;
  localparam int ARMLEOCPU_PAGE_METADATA_ACCESS_BIT_NUM  = 6;
  localparam int ARMLEOCPU_PAGE_METADATA_DIRTY_BIT_NUM   = 7;

  // Bare mode behaves like a valid, accessed, dirty RWX supervisor page.
  localparam logic [7:0] ARMLEOCPU_MMU_BARE_METADATA = 8'hCF;

  typedef struct packed {
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic [7:0]  metadata;
  } tlb_entry_t;

  function automatic logic [21:0] bare_ppn(input logic [19:0] vpn);
    return {2'b00, vpn};
  endfunction

endpackage

// File: rtl/armleocpu_mmu_xlate_if.sv
// Requester-side handshake bundle: translation request in, translation response out.
// master = load/store/fetch path, slave = translation front-end.
interface armleocpu_mmu_xlate_if;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic        resp_valid;
  logic        resp_ready;
  logic [21:0] resp_ppn;
  logic [7:0]  resp_metadata;
  logic        resp_pagefault;
  logic        resp_accessfault;

  modport master (
    output req_valid, req_vpn, resp_ready,
    input  req_ready, resp_valid, resp_ppn, resp_metadata, resp_pagefault, resp_accessfault
  );

  modport slave (
    input  req_valid, req_vpn, resp_ready,
    output req_ready, resp_valid, resp_ppn, resp_metadata, resp_pagefault, resp_accessfault
  );
endinterface

// File: rtl/armleocpu_tlb_array.sv
// Fully-associative TLB storage with parallel VPN compare, one write port and whole-array flush.
// Only the valid bits are reset; entry payload is plain storage.
module armleocpu_tlb_array
  import armleocpu_mmu_xlate_pkg::*;
#(
  parameter int ENTRIES_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_all,
  input  logic [19:0]          lookup_vpn,
  output logic                 hit,
  output logic [21:0]          hit_ppn,
  output logic [7:0]           hit_metadata,
  input  logic                 write_en,
  input  logic [ENTRIES_W-1:0] write_idx,
  input  tlb_entry_t           write_entry
);
  localparam int ENTRIES = 1 << ENTRIES_W;

  logic [ENTRIES-1:0] valid_reg;
  tlb_entry_t         entry_reg [ENTRIES];
  logic [ENTRIES-1:0] match;

  // Flush wins over a same-cycle fill; the front-end also suppresses that fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (flush_all) begin
      valid_reg <= '0;
    end else if (write_en) begin
      valid_reg[write_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      entry_reg[write_idx] <= write_entry;
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign match[gi] = valid_reg[gi] && (entry_reg[gi].vpn == lookup_vpn);
    end
  endgenerate

  // Fills only follow misses, so at most one entry matches and an OR-mux suffices.
  always_comb begin
    hit          = |match;
    hit_ppn      = '0;
    hit_metadata = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_ppn      = hit_ppn      | ({22{match[i]}} & entry_reg[i].ppn);
      hit_metadata = hit_metadata | ({8{match[i]}}  & entry_reg[i].metadata);
    end
  end

endmodule

// File: rtl/armleocpu_mmu_xlate.sv
// SV32 translation front-end: TLB lookup, PTW walk on miss, round-robin fill, response hold.
// Walk results are returned even when a concurrent invalidate cancels their fill.
module armleocpu_mmu_xlate
  import armleocpu_mmu_xlate_pkg::*;
#(
  parameter int TLB_ENTRIES_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  armleocpu_mmu_xlate_if.slave req_if,
  input  logic                 satp_mode,
  input  logic [21:0]          satp_ppn,
  input  logic                 invalidate,
  output logic                 ptw_resolve_request,
  output logic [19:0]          ptw_virtual_address,
  output logic [21:0]          ptw_satp_ppn,
  input  logic                 ptw_resolve_done,
  input  logic                 ptw_resolve_pagefault,
  input  logic                 ptw_resolve_accessfault,
  input  logic [7:0]           ptw_resolve_metadata,
  input  logic [21:0]          ptw_resolve_physical_address
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WALK_REQ  = 3'd2,
    WALK_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t                   state_reg;
  logic [19:0]              vpn_reg;
  logic                     mode_reg;
  logic                     fill_cancel_reg;
  logic [TLB_ENTRIES_W-1:0] ptr_reg;
  logic                     req_ready_reg;
  logic                     resp_valid_reg;
  logic [21:0]              resp_ppn_reg;
  logic [7:0]               resp_metadata_reg;
  logic                     resp_pagefault_reg;
  logic                     resp_accessfault_reg;
  logic                     ptw_req_reg;

  logic        tlb_hit;
  logic [21:0] tlb_hit_ppn;
  logic [7:0]  tlb_hit_metadata;
  logic        fill_en;
  tlb_entry_t  fill_entry;

  assign req_if.req_ready        = req_ready_reg;
  assign req_if.resp_valid       = resp_valid_reg;
  assign req_if.resp_ppn         = resp_ppn_reg;
  assign req_if.resp_metadata    = resp_metadata_reg;
  assign req_if.resp_pagefault   = resp_pagefault_reg;
  assign req_if.resp_accessfault = resp_accessfault_reg;

  assign ptw_resolve_request = ptw_req_reg;
  assign ptw_virtual_address = vpn_reg;
  assign ptw_satp_ppn        = satp_ppn;

  // Faults are never cached, and an invalidate anywhere in the walk cancels the fill.
  assign fill_en = (state_reg == WALK_WAIT) && ptw_resolve_done
                && !ptw_resolve_pagefault && !ptw_resolve_accessfault
                && !fill_cancel_reg && !invalidate;

  assign fill_entry = '{vpn: vpn_reg, ppn: ptw_resolve_physical_address,
                        metadata: ptw_resolve_metadata};

  armleocpu_tlb_array #(
    .ENTRIES_W (TLB_ENTRIES_W)
  ) u_tlb (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_all    (invalidate),
    .lookup_vpn   (vpn_reg),
    .hit          (tlb_hit),
    .hit_ppn      (tlb_hit_ppn),
    .hit_metadata (tlb_hit_metadata),
    .write_en     (fill_en),
    .write_idx    (ptr_reg),
    .write_entry  (fill_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      vpn_reg              <= '0;
      mode_reg             <= 1'b0;
      fill_cancel_reg      <= 1'b0;
      ptr_reg              <= '0;
      req_ready_reg        <= 1'b0;
      resp_valid_reg       <= 1'b0;
      resp_ppn_reg         <= '0;
      resp_metadata_reg    <= '0;
      resp_pagefault_reg   <= 1'b0;
      resp_accessfault_reg <= 1'b0;
      ptw_req_reg          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_if.req_valid && req_ready_reg) begin
            vpn_reg         <= req_if.req_vpn;
            mode_reg        <= satp_mode;
            fill_cancel_reg <= 1'b0;
            req_ready_reg   <= 1'b0;
            state_reg       <= LOOKUP;
          end else begin
            req_ready_reg   <= 1'b1;
          end
        end
        LOOKUP: begin
          if (!mode_reg) begin
            resp_ppn_reg         <= bare_ppn(vpn_reg);
            resp_metadata_reg    <= ARMLEOCPU_MMU_BARE_METADATA;
            resp_pagefault_reg   <= 1'b0;
            resp_accessfault_reg <= 1'b0;
            resp_valid_reg       <= 1'b1;
            state_reg            <= RESP;
          end else if (tlb_hit && !invalidate) begin
            resp_ppn_reg         <= tlb_hit_ppn;
            resp_metadata_reg    <= tlb_hit_metadata;
            resp_pagefault_reg   <= 1'b0;
            resp_accessfault_reg <= 1'b0;
            resp_valid_reg       <= 1'b1;
            state_reg            <= RESP;
          end else begin
            ptw_req_reg <= 1'b1;
            state_reg   <= WALK_REQ;
          end
        end
        WALK_REQ: begin
          ptw_req_reg <= 1'b0;
          if (invalidate) fill_cancel_reg <= 1'b1;
          state_reg   <= WALK_WAIT;
        end
        WALK_WAIT: begin
          if (invalidate) fill_cancel_reg <= 1'b1;
          if (ptw_resolve_done) begin
            resp_ppn_reg         <= ptw_resolve_physical_address;
            resp_metadata_reg    <= ptw_resolve_metadata;
            resp_pagefault_reg   <= ptw_resolve_pagefault;
            resp_accessfault_reg <= ptw_resolve_accessfault;
            resp_valid_reg       <= 1'b1;
            state_reg            <= RESP;
            if (fill_en) ptr_reg <= ptr_reg + 1'b1;
          end
        end
        RESP: begin
          if (req_if.resp_ready) begin
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_mmu_xlate.sv
// Directed bench for the SV32 translation front-end with a behavioural PTW and a FIFO TLB model.
module tb_armleocpu_mmu_xlate;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        satp_mode;
  logic [21:0] satp_ppn;
  logic        invalidate;
  logic        inv_ptw, inv_sw;
  logic        ptw_resolve_request;
  logic [19:0] ptw_virtual_address;
  logic [21:0] ptw_satp_ppn;
  logic        ptw_resolve_done;
  logic        ptw_resolve_pagefault;
  logic        ptw_resolve_accessfault;
  logic [7:0]  ptw_resolve_metadata;
  logic [21:0] ptw_resolve_physical_address;

  armleocpu_mmu_xlate_if bus ();

  assign invalidate = inv_ptw | inv_sw;

  armleocpu_mmu_xlate #(.TLB_ENTRIES_W(3)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .req_if                       (bus),
    .satp_mode                    (satp_mode),
    .satp_ppn                     (satp_ppn),
    .invalidate                   (invalidate),
    .ptw_resolve_request          (ptw_resolve_request),
    .ptw_virtual_address          (ptw_virtual_address),
    .ptw_satp_ppn                 (ptw_satp_ppn),
    .ptw_resolve_done             (ptw_resolve_done),
    .ptw_resolve_pagefault        (ptw_resolve_pagefault),
    .ptw_resolve_accessfault      (ptw_resolve_accessfault),
    .ptw_resolve_metadata         (ptw_resolve_metadata),
    .ptw_resolve_physical_address (ptw_resolve_physical_address)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model TLB: FIFO of successful, uncancelled fills, capacity 8.
  logic [19:0] m_vpn  [$];
  logic [21:0] m_ppn  [$];
  logic [7:0]  m_meta [$];

  logic [21:0] exp_ppn;
  logic [7:0]  exp_meta;
  logic        exp_pf, exp_af;
  bit          exp_active = 0;

  int          ptw_lat = 4;
  logic [21:0] ptw_ppn_cfg;
  logic [7:0]  ptw_meta_cfg;
  logic        ptw_pf_cfg, ptw_af_cfg;
  bit          inv_cfg = 0;
  bit          inv_next = 0;
  int          ptw_cnt = 0;
  int          walks = 0;
  logic [19:0] walk_va;

  logic [21:0] got_ppn;
  logic [7:0]  got_meta;
  logic        got_pf, got_af;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int model_find(input logic [19:0] v);
    for (int i = 0; i < m_vpn.size(); i++) if (m_vpn[i] == v) return i;
    return -1;
  endfunction

  function automatic void model_clear();
    m_vpn.delete(); m_ppn.delete(); m_meta.delete();
  endfunction

  function automatic void model_fill(input logic [19:0] v, input logic [21:0] p, input logic [7:0] m);
    if (m_vpn.size() == 8) begin
      void'(m_vpn.pop_front()); void'(m_ppn.pop_front()); void'(m_meta.pop_front());
    end
    m_vpn.push_back(v); m_ppn.push_back(p); m_meta.push_back(m);
  endfunction

  // Behavioural PTW: answers each request after ptw_lat cycles, optionally pulses invalidate.
  initial begin
    ptw_resolve_done = 0; ptw_resolve_pagefault = 0; ptw_resolve_accessfault = 0;
    ptw_resolve_metadata = 0; ptw_resolve_physical_address = 0; inv_ptw = 0;
    forever begin
      @(negedge clk);
      ptw_resolve_done = 0;
      inv_ptw  = inv_next;
      inv_next = 0;
      if (!rst_n) begin
        ptw_cnt = 0;
        inv_ptw = 0;
      end else if (ptw_resolve_request) begin
        walks++;
        walk_va = ptw_virtual_address;
        ptw_cnt = ptw_lat;
        if (inv_cfg) inv_next = 1;
      end else if (ptw_cnt > 0) begin
        ptw_cnt--;
        if (ptw_cnt == 0) begin
          ptw_resolve_done             = 1;
          ptw_resolve_physical_address = ptw_ppn_cfg;
          ptw_resolve_metadata         = ptw_meta_cfg;
          ptw_resolve_pagefault        = ptw_pf_cfg;
          ptw_resolve_accessfault      = ptw_af_cfg;
        end
      end
    end
  end

  // Per-cycle compare against the model's expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      check("satp_passthrough", ptw_satp_ppn, satp_ppn);
      if (!exp_active) begin
        check("resp_valid_idle", bus.resp_valid, 1'b0);
      end else if (bus.resp_valid) begin
        check("resp_ppn", bus.resp_ppn, exp_ppn);
        check("resp_meta", bus.resp_metadata, exp_meta);
        check("resp_pf", bus.resp_pagefault, exp_pf);
        check("resp_af", bus.resp_accessfault, exp_af);
        check("req_ready_busy", bus.req_ready, 1'b0);
      end
    end
  end

  task automatic do_req(input logic [19:0] vpn, input logic mode, input logic [21:0] p_ppn,
                        input logic [7:0] p_meta, input logic p_pf, input logic p_af,
                        input bit p_inv, input int hold);
    int  idx, w0, n;
    bit  exp_walk;
    ptw_ppn_cfg = p_ppn; ptw_meta_cfg = p_meta; ptw_pf_cfg = p_pf; ptw_af_cfg = p_af;
    inv_cfg = p_inv;
    exp_walk = 0;
    if (!mode) begin
      exp_ppn = {2'b00, vpn}; exp_meta = 8'hCF; exp_pf = 0; exp_af = 0;
    end else begin
      idx = model_find(vpn);
      if (idx >= 0) begin
        exp_ppn = m_ppn[idx]; exp_meta = m_meta[idx]; exp_pf = 0; exp_af = 0;
      end else begin
        exp_walk = 1;
        exp_ppn = p_ppn; exp_meta = p_meta; exp_pf = p_pf; exp_af = p_af;
        if (p_inv) model_clear();
        else if (!p_pf && !p_af) model_fill(vpn, p_ppn, p_meta);
      end
    end
    w0 = walks;
    exp_active = 1;
    @(negedge clk);
    bus.req_valid = 1; bus.req_vpn = vpn; satp_mode = mode;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    n = 1;
    while (!bus.resp_valid && n < 100) begin @(negedge clk); n++; end
    check("resp_valid_seen", bus.resp_valid, 1'b1);
    if (!exp_walk) check("hit_latency", n, 2);
    check("walk_count", walks - w0, exp_walk);
    if (exp_walk) check("walk_va", walk_va, vpn);
    got_ppn = bus.resp_ppn; got_meta = bus.resp_metadata;
    got_pf = bus.resp_pagefault; got_af = bus.resp_accessfault;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.resp_valid, 1'b1);
      check("hold_ppn", bus.resp_ppn, got_ppn);
      check("hold_meta", bus.resp_metadata, got_meta);
    end
    bus.resp_ready = 1;
    @(posedge clk);
    #1 exp_active = 0;
    @(negedge clk);
    bus.resp_ready = 0;
    check("req_ready_after_resp", bus.req_ready, 1'b1);
    $display("txn vpn=%h mode=%0d walk=%0d ppn=%h meta=%h pf=%0d af=%0d",
             vpn, mode, exp_walk, got_ppn, got_meta, got_pf, got_af);
  endtask

  task automatic pulse_inv();
    @(negedge clk); inv_sw = 1;
    @(negedge clk); inv_sw = 0;
    model_clear();
    $display("txn invalidate");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, n;
    rst_n = 0; satp_mode = 0; satp_ppn = 22'h01234; inv_sw = 0;
    bus.req_valid = 0; bus.req_vpn = 0; bus.resp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_ptw_req", ptw_resolve_request, 1'b0);
    check("rst_resp_ppn", bus.resp_ppn, 22'h0);
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    check("req_ready_after_rst", bus.req_ready, 1'b1);

    // Bare mode
    do_req(20'hABCDE, 0, 22'h0, 8'h0, 0, 0, 0, 0);
    check("bare_ppn_lit", got_ppn, 22'h0ABCDE);
    check("bare_meta_lit", got_meta, 8'hCF);

    // Miss then hit, then hit under backpressure
    do_req(20'h12345, 1, 22'h3F0001, 8'hCF, 0, 0, 0, 0);
    check("miss_ppn_lit", got_ppn, 22'h3F0001);
    do_req(20'h12345, 1, 22'h111111, 8'h00, 0, 0, 0, 0);
    check("hit_ppn_lit", got_ppn, 22'h3F0001);
    do_req(20'h12345, 1, 22'h111111, 8'h00, 0, 0, 0, 5);

    // Faults are not cached; both flags forwarded
    do_req(20'h00010, 1, 22'h000AAA, 8'h00, 1, 0, 0, 0);
    check("pf_lit", got_pf, 1'b1);
    do_req(20'h00010, 1, 22'h000AAA, 8'h00, 1, 0, 0, 0);
    do_req(20'h00020, 1, 22'h000BBB, 8'h01, 1, 1, 0, 0);
    check("both_faults_lit", {got_pf, got_af}, 2'b11);

    // Invalidate during the walk: result returned, nothing filled, old hits gone
    do_req(20'h00030, 1, 22'h0C0030, 8'hDF, 0, 0, 1, 0);
    check("inv_walk_ppn_lit", got_ppn, 22'h0C0030);
    do_req(20'h00030, 1, 22'h0C0030, 8'hDF, 0, 0, 0, 0);
    do_req(20'h12345, 1, 22'h3F0002, 8'hCF, 0, 0, 0, 0);
    check("rewalk_ppn_lit", got_ppn, 22'h3F0002);

    // Replacement wrap after a full flush
    pulse_inv();
    for (int i = 0; i < 9; i++)
      do_req(20'h00100 + 20'(i), 1, 22'h100000 + 22'(i), 8'hCF, 0, 0, 0, 0);
    w0 = walks;
    do_req(20'h00101, 1, 22'h2FFFFF, 8'hCF, 0, 0, 0, 0);
    check("second_still_hits_lit", got_ppn, 22'h100001);
    do_req(20'h00100, 1, 22'h200100, 8'hCF, 0, 0, 0, 0);
    check("first_evicted_walks_lit", walks - w0, 1);

    // Reset in the middle of a walk
    ptw_lat = 20;
    ptw_ppn_cfg = 22'h3AAAAA; ptw_meta_cfg = 8'hCF; ptw_pf_cfg = 0; ptw_af_cfg = 0; inv_cfg = 0;
    exp_active = 1;
    @(negedge clk);
    bus.req_valid = 1; bus.req_vpn = 20'h00200; satp_mode = 1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 0;
    w0 = walks; n = 0;
    while (walks == w0 && n < 20) begin @(negedge clk); n++; end
    check("midwalk_request", walks - w0, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_req_ready", bus.req_ready, 1'b0);
    check("async_rst_resp_valid", bus.resp_valid, 1'b0);
    check("async_rst_ptw_req", ptw_resolve_request, 1'b0);
    check("async_rst_resp_meta", bus.resp_metadata, 8'h00);
    exp_active = 0;
    model_clear();
    $display("txn reset mid-walk vpn=00200");
    repeat (2) @(negedge clk);
    rst_n = 1;
    ptw_lat = 4;
    @(posedge clk); @(negedge clk);
    w0 = walks;
    do_req(20'h00101, 1, 22'h300101, 8'hCF, 0, 0, 0, 0);
    check("tlb_empty_after_rst", walks - w0, 1);
    check("tlb_empty_ppn_lit", got_ppn, 22'h300101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/armleocpu_mmu_xlate.md
# armleocpu_mmu_xlate

SV32 translation front-end between the load/store/fetch path and `armleocpu_ptw`. It accepts virtual page numbers and looks them up in a small fully-associative TLB. On a miss it launches a walk on the PTW, fills the TLB from the 4K-page result, and returns PPN, metadata or fault to the requester. It is also the block that drives the PTW's `resolve_request` / `virtual_address` / `satp_ppn` inputs.

## Interface
- `TLB_ENTRIES_W`, 3, log2 of TLB entry count (8 entries)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  translation request
- `req_ready`  out  1  request accepted when both high
- `req_vpn`  in  20  virtual page number
- `resp_valid`  out  1  response available, held until `resp_ready`
- `resp_ready`  in  1  response consumed
- `resp_ppn`  out  22  physical page number
- `resp_metadata`  out  8  PTE bits [7:0] (V,R,W,X,U,G,A,D)
- `resp_pagefault`  out  1  page fault
- `resp_accessfault`  out  1  access fault
- `satp_mode`  in  1  0 = bare, 1 = SV32
- `satp_ppn`  in  22  root table PPN
- `invalidate`  in  1  single-cycle pulse, flush whole TLB (sfence.vma)
- `ptw_resolve_request`  out  1  to PTW
- `ptw_virtual_address`  out  20  to PTW
- `ptw_satp_ppn`  out  22  to PTW, direct pass-through of `satp_ppn`
- `ptw_resolve_done`, `ptw_resolve_pagefault`, `ptw_resolve_accessfault`  in  1 each  from PTW
- `ptw_resolve_metadata`  in  8  from PTW
- `ptw_resolve_physical_address`  in  22  from PTW

## Operation
- **States:** IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On handshake, register `req_vpn` and `satp_mode`, clear `fill_cancel`, go to LOOKUP.
- **LOOKUP:**
  - If saved mode = 0: response is PPN `{2'b00, vpn}`, metadata `8'hCF`, no fault; go to RESP.
  - Otherwise compare the VPN against all valid entries in parallel.
  - Hit: latch that entry's PPN and metadata, no fault; go to RESP.
  - Miss: go to WALK_REQ.
  - An `invalidate` in the same cycle forces a miss.
- **WALK_REQ:** `ptw_resolve_request` = 1 for exactly this one cycle; go to WALK_WAIT.
- **`ptw_virtual_address`:** driven from the saved VPN in all states.
- **WALK_WAIT:** on `ptw_resolve_done`:
  - Latch the PTW PPN, metadata and fault flags; go to RESP.
  - If there is no fault and `fill_cancel` = 0, write the entry at the round-robin pointer and increment the pointer (wraps at 2^TLB_ENTRIES_W − 1 → 0).
- **RESP:** `resp_valid` = 1 and outputs stable until `resp_ready`, then go to IDLE.
- **Faults:** never cached. If the PTW reports both fault flags, both are forwarded unchanged.
- **`invalidate`:**
  - Clears all entry valid bits at the next edge, in any state.
  - If asserted in WALK_REQ, in WALK_WAIT, or in the same cycle as `ptw_resolve_done`, it sets `fill_cancel`. The walk result is still returned but not filled.
- **Duplicate entries:** no duplicate check is needed, because a fill only follows a miss.

## Timing
- **Reset (async):**
  - state IDLE, all valid bits 0, pointer 0, `fill_cancel` 0.
  - `resp_*` = 0, `ptw_resolve_request` = 0.
  - `req_ready` = 0 while `rst_n` is low, and 1 from the first cycle after deassertion.
- **Hit or bare latency:** accept at cycle 0, `resp_valid` at cycle 2.
- **Miss latency:**
  - accept 0, LOOKUP 1, request 2.
  - `resp_valid` 1 cycle after `ptw_resolve_done`.
  - The PTW currently takes at least 4 cycles of AXI round trip per level.
- **Request pulse:** `ptw_resolve_request` is never asserted in the cycle of, or the cycle after, `ptw_resolve_done`. This guarantees the PTW does not restart from IDLE.
- **Requests during a walk:** no new request is accepted until RESP completes; `req_ready` = 0 outside IDLE.
- **Mode changes:** a `satp_mode`/`satp_ppn` change mid-walk has no effect on the in-flight walk beyond what the PTW sampled. Software must `invalidate` after changing satp.
- **Reset mid-walk:** returns to IDLE and drops all state. The PTW is reset by the same `rst_n`.

## Structure
- **Shared defines header:** the existing `ARMLEOCPU_PAGE_METADATA_*_BIT_NUM` constants, plus a new `ARMLEOCPU_MMU_BARE_METADATA` = `8'hCF`.
- **Local constants:** state encodings stay local (3-bit localparams).
- **Sub-module `armleocpu_tlb_array`:**
  - valid/VPN/PPN/metadata storage and a parallel compare giving `hit` and the hit data.
  - a write port (index, data) and `flush_all`.
  - The async reset clears only the valid bits.

## Test plan
- **Bare mode:** `satp_mode`=0, vpn `20'hABCDE` → `resp_ppn` = `22'h0ABCDE`, metadata `8'hCF`, `resp_valid` at cycle 2, no PTW request.
- **Miss then hit:**
  - vpn `20'h12345`, PTW returns PPN `22'h3F0001`, metadata `8'hCF` → response after done, one fill.
  - Same vpn again → hit at cycle 2, no `ptw_resolve_request`.
- **Page fault not cached:** PTW returns pagefault for vpn `20'h00010` → `resp_pagefault`=1. A repeat request issues a new walk.
- **Invalidate mid-walk:** pulse `invalidate` in WALK_WAIT → result returned, no fill. The next request for the same VPN walks again; all older hits now miss.
- **Replacement wrap:** 9 distinct successful misses → the 9th evicts entry 0 (first VPN). Re-requesting the first VPN walks; the second VPN still hits.
- **Backpressure and reset:**
  - Hold `resp_ready`=0 for 5 cycles → outputs stable, `req_ready`=0.
  - Assert `rst_n`=0 mid-walk → all outputs 0 immediately, TLB empty after release.
